// File: rtl/stream_pattern_gen.sv
// Rate-limited test-stream source: emits counter, LFSR, walking-one or inverted-counter
// words over valid/ready, counting rate slots lost to backpressure without skipping pattern values.
module stream_pattern_gen #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DIV_W     = 5,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  period,
    input  logic [DATA_W-1:0] seed,
    input  logic [CNT_W-1:0]  burst_len,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [DATA_W-1:0] POLY = DATA_W'(LFSR_POLY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]        mode_r;
    logic [DIV_W-1:0]  period_r;
    logic [DIV_W-1:0]  timer;
    logic [CNT_W-1:0]  burst_r;
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] pattern_nxt;
    logic [DATA_W-1:0] pattern_out;
    logic [DATA_W-1:0] start_pattern;

    logic tick;
    logic accept;
    logic last_accept;
    logic load;
    logic drop;

    always_comb begin
        tick        = (state == RUN) && en && (timer == period_r);
        accept      = valid && ready;
        last_accept = accept && (burst_r != '0) && ((word_cnt + CNT_W'(1)) == burst_r);
        // The final accept blocks any same-cycle load so the burst ends exactly on burst_len.
        load        = tick && (!valid || ready) && !last_accept;
        drop        = tick && valid && !ready;
    end

    always_comb begin
        pattern_nxt = pattern + DATA_W'(1);
        pattern_out = pattern;
        case (mode_r)
            2'd0: pattern_nxt = pattern + DATA_W'(1);
            2'd1: pattern_nxt = (pattern >> 1) ^ (pattern[0] ? POLY : '0);
            2'd2: pattern_nxt = {pattern[DATA_W-2:0], pattern[DATA_W-1]};
            2'd3: begin
                // Inverted-counter mode keeps a plain counter internally and inverts on output.
                pattern_nxt = pattern + DATA_W'(1);
                pattern_out = ~pattern;
            end
            default: pattern_nxt = pattern + DATA_W'(1);
        endcase
    end

    always_comb begin
        start_pattern = seed;
        if (mode == 2'd1 && seed == '0) begin
            start_pattern = DATA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_accept) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r   <= '0;
            period_r <= '0;
            burst_r  <= '0;
            timer    <= '0;
            pattern  <= '0;
            data     <= '0;
            valid    <= 1'b0;
            word_cnt <= '0;
            drop_cnt <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                mode_r   <= mode;
                period_r <= period;
                burst_r  <= burst_len;
                pattern  <= start_pattern;
                timer    <= '0;
                valid    <= 1'b0;
                word_cnt <= '0;
                drop_cnt <= '0;
            end
        end else if (state == RUN) begin
            if (en) begin
                timer <= (timer == period_r) ? '0 : timer + DIV_W'(1);
            end
            if (accept) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (load) begin
                data    <= pattern_out;
                valid   <= 1'b1;
                pattern <= pattern_nxt;
            end else if (accept) begin
                valid <= 1'b0;
            end
            if (drop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
